// File: rtl/regfile_pkg.sv
// Shared types and defaults for the general-purpose register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int RF_DEFAULT_DW   = 32;
  localparam int RF_DEFAULT_NREG = 32;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: not-ready gate, hardwired zero, write bypass, array data.
module regfile_rdport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          ready,
  input  logic [AW-1:0] rn,
  input  logic          we,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] mem_q,
  output logic [DW-1:0] q
);

  // First match wins; the order matters when several conditions overlap.
  always_comb begin
    q = mem_q;
    if (!ready)
      q = '0;
    else if ((ZERO_REG != 0) && (rn == '0))
      q = '0;
    else if ((BYPASS != 0) && we && (wn == rn))
      q = d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file: two combinational read ports, one write port, self-clearing after clr.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DEFAULT_DW,
  parameter int NREG     = RF_DEFAULT_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] d,
  input  logic          we,
  output logic          ready,
  output logic          wr_drop
);

  localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  logic [DW-1:0] mem [NREG];

  rf_state_t     state, state_next;
  logic [AW-1:0] idx, idx_next;
  logic          drop_next;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  assign ready = (state == RUN);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    drop_next  = wr_drop;
    mem_we     = 1'b0;
    mem_wa     = wn;
    mem_wd     = d;
    if (clr) begin
      state_next = INIT;
      idx_next   = FIRST_IDX;
      drop_next  = 1'b0;
    end else begin
      case (state)
        INIT: begin
          // The clear sequencer owns the write port; user writes are dropped.
          mem_we   = 1'b1;
          mem_wa   = idx;
          mem_wd   = '0;
          idx_next = idx + AW'(1);
          if (idx == LAST_IDX) state_next = RUN;
          if (we) drop_next = 1'b1;
        end
        RUN: begin
          mem_we = we && !((ZERO_REG != 0) && (wn == '0));
        end
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state   <= state_next;
    idx     <= idx_next;
    wr_drop <= drop_next;
  end

  // Storage has no reset of its own; the INIT sequence clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  regfile_rdport #(
    .DW(DW), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .ready(ready), .rn(rna), .we(we), .wn(wn), .d(d), .mem_q(mem[rna]), .q(qa)
  );

  regfile_rdport #(
    .DW(DW), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .ready(ready), .rn(rnb), .we(we), .wn(wn), .d(d), .mem_q(mem[rnb]), .q(qb)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: four builds of regfile_mp share one stimulus stream.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  rna = '0, rnb = '0, wn = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;

  logic [31:0] q0a, q0b, q1a, q1b, q2a, q2b;
  logic [15:0] q3a, q3b;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        drop0, drop1, drop2, drop3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0 defaults, u1 no zero register, u2 no bypass, u3 small build
  regfile_mp u0 (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(q0a), .qb(q0b),
    .wn(wn), .d(d), .we(we), .ready(rdy0), .wr_drop(drop0)
  );
  regfile_mp #(.ZERO_REG(0)) u1 (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(q1a), .qb(q1b),
    .wn(wn), .d(d), .we(we), .ready(rdy1), .wr_drop(drop1)
  );
  regfile_mp #(.BYPASS(0)) u2 (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(q2a), .qb(q2b),
    .wn(wn), .d(d), .we(we), .ready(rdy2), .wr_drop(drop2)
  );
  regfile_mp #(.DW(16), .NREG(8)) u3 (
    .clk(clk), .clr(clr), .rna(rna[2:0]), .rnb(rnb[2:0]), .qa(q3a), .qb(q3b),
    .wn(wn[2:0]), .d(d[15:0]), .we(we), .ready(rdy3), .wr_drop(drop3)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;     // u0
    logic [31:0] qb;     // u0
    logic [31:0] qa_nb;  // u2
    logic [31:0] qa_z0;  // u1
  } vec_t;

  vec_t tbl[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  // Counts edges until u0 reports ready, bounded.
  task automatic wait_ready0(output int n);
    n = 0;
    while (!rdy0 && n < 100) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, r0, r1, r2, r3;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'hFFFFFFFF};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hFFFFFFFF};
    tbl[5] = '{1'b1, 5'd7,  32'h1,        5'd7, 5'd3,  32'h1,        32'h0,        32'h0,        32'h1};
    tbl[6] = '{1'b1, 5'd7,  32'h2,        5'd7, 5'd7,  32'h2,        32'h2,        32'h1,        32'h2};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  32'h2,        32'h2,        32'h2,        32'h2};

    // Reset and clear latency of every build
    #1;
    rna = 5'd5;
    rnb = 5'd31;
    pulse_clr();
    chk("rst_ready", {31'b0, rdy0}, 32'h0);
    chk("rst_drop", {31'b0, drop0}, 32'h0);
    r0 = -1; r1 = -1; r2 = -1; r3 = -1;
    for (int i = 0; i < 40; i++) begin
      if (rdy0 && r0 < 0) r0 = i;
      if (rdy1 && r1 < 0) r1 = i;
      if (rdy2 && r2 < 0) r2 = i;
      if (rdy3 && r3 < 0) r3 = i;
      if (i == 5 || i == 30) chk("init_qa_zero", q0a, 32'h0);
      cyc();
    end
    chk("lat_default", r0, 32'd31);
    chk("lat_nozero", r1, 32'd32);
    chk("lat_nobypass", r2, 32'd31);
    chk("lat_small", r3, 32'd7);

    for (int r = 0; r < 32; r++) begin
      rna = 5'(r);
      rnb = 5'(31 - r);
      #1;
      chk("clear_qa", q0a, 32'h0);
      chk("clear_qb", q0b, 32'h0);
      chk("clear_qa_nozero", q1a, 32'h0);
    end

    // Table of writes and reads in RUN
    for (int i = 0; i < 8; i++) begin
      we = tbl[i].we; wn = tbl[i].wn; d = tbl[i].d;
      rna = tbl[i].rna; rnb = tbl[i].rnb;
      #1;
      chk($sformatf("vec%0d_qa", i), q0a, tbl[i].qa);
      chk($sformatf("vec%0d_qb", i), q0b, tbl[i].qb);
      chk($sformatf("vec%0d_qa_nobypass", i), q2a, tbl[i].qa_nb);
      chk($sformatf("vec%0d_qa_nozero", i), q1a, tbl[i].qa_z0);
      cyc();
    end
    we = 1'b0;
    chk("run_no_drop", {31'b0, drop0}, 32'h0);

    // Small build write/read
    we = 1'b1; wn = 5'd6; d = 32'h0000BEEF;
    cyc();
    we = 1'b0; rna = 5'd6;
    #1;
    chk("small_r6", {16'h0, q3a}, 32'h0000BEEF);

    // Dropped write during INIT
    pulse_clr();
    for (int i = 0; i < 10; i++) cyc();
    chk("drop_before", {31'b0, drop0}, 32'h0);
    we = 1'b1; wn = 5'd3; d = 32'hA5A5A5A5;
    cyc();
    we = 1'b0;
    chk("drop_set", {31'b0, drop0}, 32'h1);
    chk("drop_set_nozero", {31'b0, drop1}, 32'h1);
    wait_ready0(n);
    rna = 5'd3;
    #1;
    chk("drop_r3_zero", q0a, 32'h0);
    chk("drop_sticky", {31'b0, drop0}, 32'h1);
    pulse_clr();
    chk("drop_cleared", {31'b0, drop0}, 32'h0);
    wait_ready0(n);

    // clr in RUN clears contents again
    we = 1'b1; wn = 5'd9; d = 32'h55;
    cyc();
    we = 1'b0; rna = 5'd9;
    #1;
    chk("r9_written", q0a, 32'h55);
    pulse_clr();
    chk("mid_ready_low", {31'b0, rdy0}, 32'h0);
    chk("mid_qa_zero", q0a, 32'h0);
    wait_ready0(n);
    chk("mid_latency", n, 32'd31);
    chk("mid_r9_zero", q0a, 32'h0);

    // clr reasserted partway through INIT restarts the count
    pulse_clr();
    for (int i = 0; i < 20; i++) cyc();
    chk("restart_not_ready", {31'b0, rdy0}, 32'h0);
    pulse_clr();
    wait_ready0(n);
    chk("restart_latency", n, 32'd31);

    // we together with clr: clr wins, no drop
    clr = 1'b1; we = 1'b1; wn = 5'd4; d = 32'h77;
    cyc();
    clr = 1'b0; we = 1'b0;
    chk("clr_we_no_drop", {31'b0, drop0}, 32'h0);
    wait_ready0(n);
    rna = 5'd4;
    #1;
    chk("clr_we_r4_zero", q0a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
